// File: rtl/issue_arbiter.sv
// Oldest-first issue arbiter for one ALU port and one multi-cycle MDU port.
// Age is the modular distance of each entry's ROB tag from the ROB head.
module issue_arbiter #(
   parameter int RS_ENTRIES = 8,
   parameter int TAG_W      = 4,
   parameter int MDU_LAT    = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          flush,
   input  logic [TAG_W-1:0]              rob_head_tag,
   input  logic [RS_ENTRIES-1:0]         rs_valid,
   input  logic [RS_ENTRIES-1:0]         rs_ready,
   input  logic [RS_ENTRIES-1:0]         rs_is_mdu,
   input  logic [RS_ENTRIES*TAG_W-1:0]   rs_tag,
   output logic                          alu_grant_valid,
   output logic [$clog2(RS_ENTRIES)-1:0] alu_grant_idx,
   output logic                          mdu_grant_valid,
   output logic [$clog2(RS_ENTRIES)-1:0] mdu_grant_idx,
   output logic                          mdu_busy,
   output logic                          mdu_done,
   output logic [TAG_W-1:0]              mdu_done_tag,
   output logic                          mdu_stall
);

   localparam int IDX_W = $clog2(RS_ENTRIES);
   localparam int CNT_W = $clog2(MDU_LAT) + 1;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [TAG_W-1:0]   r_done_tag;

   logic [RS_ENTRIES-1:0] w_alu_elig;
   logic [RS_ENTRIES-1:0] w_mdu_elig;
   logic [TAG_W-1:0]      w_age [RS_ENTRIES];

   logic                  w_alu_any;
   logic [IDX_W-1:0]      w_alu_sel;
   logic [TAG_W-1:0]      w_alu_best;
   logic                  w_mdu_any;
   logic [IDX_W-1:0]      w_mdu_sel;
   logic [TAG_W-1:0]      w_mdu_best;
   logic [TAG_W-1:0]      w_mdu_tag;

   logic                  w_live;
   logic                  w_idle;
   logic                  w_busy;

   assign w_alu_elig = rs_valid & rs_ready & ~rs_is_mdu;
   assign w_mdu_elig = rs_valid & rs_ready & rs_is_mdu;

   // Modular subtraction makes ROB wrap-around transparent to the compare.
   always_comb begin
      for (int i = 0; i < RS_ENTRIES; i++) begin
         w_age[i] = rs_tag[i*TAG_W +: TAG_W] - rob_head_tag;
      end
   end

   // Strict less-than keeps the lowest index on equal ages.
   always_comb begin
      w_alu_any  = 1'b0;
      w_alu_sel  = '0;
      w_alu_best = '0;
      w_mdu_any  = 1'b0;
      w_mdu_sel  = '0;
      w_mdu_best = '0;
      w_mdu_tag  = '0;
      for (int i = 0; i < RS_ENTRIES; i++) begin
         if (w_alu_elig[i] && (!w_alu_any || w_age[i] < w_alu_best)) begin
            w_alu_any  = 1'b1;
            w_alu_sel  = IDX_W'(i);
            w_alu_best = w_age[i];
         end
         if (w_mdu_elig[i] && (!w_mdu_any || w_age[i] < w_mdu_best)) begin
            w_mdu_any  = 1'b1;
            w_mdu_sel  = IDX_W'(i);
            w_mdu_best = w_age[i];
            w_mdu_tag  = rs_tag[i*TAG_W +: TAG_W];
         end
      end
   end

   assign w_live = ~reset & ~flush;
   assign w_idle = (r_state == S_IDLE);
   assign w_busy = (r_state == S_BUSY);

   assign alu_grant_valid = w_alu_any & w_live;
   assign alu_grant_idx   = alu_grant_valid ? w_alu_sel : '0;
   assign mdu_grant_valid = w_mdu_any & w_idle & w_live;
   assign mdu_grant_idx   = mdu_grant_valid ? w_mdu_sel : '0;
   assign mdu_busy        = w_busy & ~reset;
   assign mdu_done        = w_busy & (r_cnt == '0) & w_live;
   assign mdu_done_tag    = r_done_tag;
   assign mdu_stall       = w_mdu_any & w_busy & w_live;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_done_tag <= '0;
      end else if (flush) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (mdu_grant_valid) begin
                  r_state    <= S_BUSY;
                  r_cnt      <= CNT_W'(MDU_LAT - 1);
                  r_done_tag <= w_mdu_tag;
               end
            end
            S_BUSY: begin
               if (r_cnt == '0) begin
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_issue_arbiter.sv
// Scoreboard bench for issue_arbiter: stimulus pushes expected outputs,
// a monitor pops and compares them mid-cycle.
module tb_issue_arbiter;

   localparam int N   = 8;
   localparam int TW  = 4;
   localparam int LAT = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          flush;
   logic [TW-1:0] rob_head_tag;
   logic [N-1:0]  rs_valid;
   logic [N-1:0]  rs_ready;
   logic [N-1:0]  rs_is_mdu;
   logic [N*TW-1:0] rs_tag;
   logic          alu_grant_valid;
   logic [2:0]    alu_grant_idx;
   logic          mdu_grant_valid;
   logic [2:0]    mdu_grant_idx;
   logic          mdu_busy;
   logic          mdu_done;
   logic [TW-1:0] mdu_done_tag;
   logic          mdu_stall;

   issue_arbiter #(.RS_ENTRIES(N), .TAG_W(TW), .MDU_LAT(LAT)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .rob_head_tag(rob_head_tag),
      .rs_valid(rs_valid), .rs_ready(rs_ready),
      .rs_is_mdu(rs_is_mdu), .rs_tag(rs_tag),
      .alu_grant_valid(alu_grant_valid), .alu_grant_idx(alu_grant_idx),
      .mdu_grant_valid(mdu_grant_valid), .mdu_grant_idx(mdu_grant_idx),
      .mdu_busy(mdu_busy), .mdu_done(mdu_done),
      .mdu_done_tag(mdu_done_tag), .mdu_stall(mdu_stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      int alu_v; int alu_i;
      int mdu_v; int mdu_i;
      int busy;  int done;
      int dtag;  int stall;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;

   // model state: remaining MDU occupancy cycles and last issued MDU tag
   int busy_left = 0;
   int m_dtag = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int tag_of(input logic [N*TW-1:0] t, input int i);
      return int'(t[i*TW +: TW]);
   endfunction

   // oldest = smallest distance from head; scan ages upward, then indices
   task automatic pick(input logic [N-1:0] el, input logic [N*TW-1:0] t,
                       input int head, output int any, output int idx);
      any = 0;
      idx = 0;
      for (int a = 0; a < (1 << TW) && any == 0; a++) begin
         for (int i = 0; i < N; i++) begin
            if (any == 0 && el[i] &&
                ((tag_of(t, i) - head + (1 << TW)) % (1 << TW)) == a) begin
               any = 1;
               idx = i;
            end
         end
      end
   endtask

   task automatic drive(input logic [N-1:0] v, input logic [N-1:0] r,
                        input logic [N-1:0] m, input logic [N*TW-1:0] t,
                        input int head, input bit fl);
      exp_t e;
      int aany, aidx, many, midx;
      @(negedge clk);
      rs_valid = v;
      rs_ready = r;
      rs_is_mdu = m;
      rs_tag = t;
      rob_head_tag = TW'(head);
      flush = fl;
      pick(v & r & ~m, t, head, aany, aidx);
      pick(v & r & m, t, head, many, midx);
      e.alu_v = (aany == 1 && !fl) ? 1 : 0;
      e.alu_i = e.alu_v ? aidx : 0;
      e.mdu_v = (many == 1 && busy_left == 0 && !fl) ? 1 : 0;
      e.mdu_i = e.mdu_v ? midx : 0;
      e.busy  = (busy_left > 0) ? 1 : 0;
      e.done  = (busy_left == 1 && !fl) ? 1 : 0;
      e.stall = (many == 1 && busy_left > 0 && !fl) ? 1 : 0;
      e.dtag  = m_dtag;
      q.push_back(e);
      if (fl) busy_left = 0;
      else if (e.mdu_v == 1) begin
         busy_left = LAT;
         m_dtag = tag_of(t, midx);
      end else if (busy_left > 0) busy_left--;
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) drive('0, '0, '0, '0, 0, 1'b0);
   endtask

   function automatic logic [N*TW-1:0] tg2(input int i, input int ti,
                                          input int j, input int tj);
      logic [N*TW-1:0] t;
      t = '0;
      t[i*TW +: TW] = TW'(ti);
      t[j*TW +: TW] = TW'(tj);
      return t;
   endfunction

   // monitor: compares whatever expectation the stimulus queued this cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("alu_v", int'(alu_grant_valid), e.alu_v);
            chk("alu_idx", int'(alu_grant_idx), e.alu_i);
            chk("mdu_v", int'(mdu_grant_valid), e.mdu_v);
            chk("mdu_idx", int'(mdu_grant_idx), e.mdu_i);
            chk("busy", int'(mdu_busy), e.busy);
            chk("done", int'(mdu_done), e.done);
            chk("stall", int'(mdu_stall), e.stall);
            if (e.done == 1) chk("done_tag", int'(mdu_done_tag), e.dtag);
         end
      end
   end

   task automatic chk_all_zero(input string nm);
      chk({nm, "_alu_v"}, int'(alu_grant_valid), 0);
      chk({nm, "_mdu_v"}, int'(mdu_grant_valid), 0);
      chk({nm, "_busy"}, int'(mdu_busy), 0);
      chk({nm, "_done"}, int'(mdu_done), 0);
      chk({nm, "_stall"}, int'(mdu_stall), 0);
      chk({nm, "_dtag"}, int'(mdu_done_tag), 0);
   endtask

   initial begin
      reset = 1'b1;
      flush = 1'b0;
      rob_head_tag = '0;
      rs_valid = '1;
      rs_ready = '1;
      rs_is_mdu = 8'h0F;
      rs_tag = '0;
      #1;
      chk_all_zero("reset");
      #1;
      reset = 1'b0;
      rs_valid = '0;

      // age ordering across ROB wrap
      drive(8'h24, '1, '0, tg2(2, 7, 5, 3), 0, 1'b0);
      #2 chk("age_head0", int'(alu_grant_idx), 5);
      drive(8'h24, '1, '0, tg2(2, 7, 5, 3), 6, 1'b0);
      #2 chk("age_head6", int'(alu_grant_idx), 2);
      // equal tags go to the lower index
      drive(8'h12, '1, '0, tg2(1, 9, 4, 9), 0, 1'b0);
      #2 chk("tie_idx", int'(alu_grant_idx), 1);

      // MDU occupancy, stall and back-to-back grant
      drive(8'h01, '1, 8'h01, tg2(0, 6, 1, 8), 0, 1'b0);
      for (int k = 0; k < LAT; k++)
         drive(8'h02, '1, 8'h02, tg2(0, 6, 1, 8), 0, 1'b0);
      #2 chk("lat_done", int'(mdu_done), 1);
      chk("lat_done_tag", int'(mdu_done_tag), 6);
      drive(8'h02, '1, 8'h02, tg2(0, 6, 1, 8), 0, 1'b0);
      #2 chk("second_grant_idx", int'(mdu_grant_idx), 1);
      idle_cycles(LAT + 1);

      // both ports in the same cycle
      drive(8'h11, '1, 8'h10, tg2(0, 2, 4, 3), 0, 1'b0);
      #2 chk("dual_alu", int'(alu_grant_valid), 1);
      chk("dual_mdu_idx", int'(mdu_grant_idx), 4);
      idle_cycles(LAT + 1);

      // flush kills the in-flight MDU op
      drive(8'h01, '1, 8'h01, tg2(0, 6, 1, 8), 0, 1'b0);
      idle_cycles(1);
      drive(8'h03, '1, 8'h01, tg2(0, 6, 1, 8), 0, 1'b1);
      #2 chk("flush_no_alu", int'(alu_grant_valid), 0);
      idle_cycles(1);
      #2 chk("flush_busy", int'(mdu_busy), 0);
      idle_cycles(LAT + 1);

      // async reset mid-operation
      drive(8'h01, '1, 8'h01, tg2(0, 6, 1, 8), 0, 1'b0);
      drive(8'h02, '1, 8'h02, tg2(0, 5, 1, 8), 0, 1'b0);
      #3;
      reset = 1'b1;
      #1;
      chk_all_zero("midreset");
      busy_left = 0;
      m_dtag = 0;
      @(negedge clk);
      reset = 1'b0;
      rs_valid = '0;
      drive(8'h02, '1, 8'h02, tg2(0, 5, 1, 8), 0, 1'b0);
      #2 chk("post_reset_grant", int'(mdu_grant_valid), 1);

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         drive(N'($urandom), N'($urandom | $urandom), N'($urandom),
               (N*TW)'($urandom), int'($urandom_range(0, (1 << TW) - 1)),
               ($urandom_range(0, 19) == 0));
      end
      idle_cycles(2);
      @(negedge clk);
      #4;
      if (q.size() != 0) chk("queue_drain", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/issue_arbiter.md
ISSUE_ARBITER -- requirements
Module: issue_arbiter

Interface
REQ-001 Parameter RS_ENTRIES, 8, number of reservation-station entries arbitrated (power of two, >=2).
REQ-002 Parameter TAG_W, 4, ROB tag width; equals `ROB_SIZE_WIDTH.
REQ-003 Parameter MDU_LAT, 4, MDU occupancy in cycles per operation (>=1).
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 flush  in  1  branch-recovery flush; kills grants and any MDU operation in flight.
REQ-007 rob_head_tag  in  TAG_W  tag of oldest ROB entry; age reference.
REQ-008 rs_valid  in  RS_ENTRIES  entry occupied.
REQ-009 rs_ready  in  RS_ENTRIES  all source operands available.
REQ-010 rs_is_mdu  in  RS_ENTRIES  entry needs MDU (mul/div); else ALU.
REQ-011 rs_tag  in  RS_ENTRIES*TAG_W  packed ROB tags; entry i at bits [i*TAG_W +: TAG_W].
REQ-012 alu_grant_valid  out  1  ALU issue this cycle.
REQ-013 alu_grant_idx  out  clog2(RS_ENTRIES)  entry issued to ALU.
REQ-014 mdu_grant_valid  out  1  MDU issue this cycle.
REQ-015 mdu_grant_idx  out  clog2(RS_ENTRIES)  entry issued to MDU.
REQ-016 mdu_busy  out  1  MDU occupied (state BUSY).
REQ-017 mdu_done  out  1  one-cycle pulse, MDU result complete.
REQ-018 mdu_done_tag  out  TAG_W  ROB tag of completing MDU operation, valid with mdu_done.
REQ-019 mdu_stall  out  1  an eligible MDU entry exists but MDU is busy (feeds stall generation).

Function
REQ-020 Age of entry i SHALL be (rs_tag[i] - rob_head_tag) mod 2^TAG_W; smaller age = older; ROB wrap-around handled solely by this modular subtraction.
REQ-021 ALU-eligible: rs_valid & rs_ready & ~rs_is_mdu; MDU-eligible: rs_valid & rs_ready & rs_is_mdu.
REQ-022 Grants SHALL be combinational (zero latency): each port selects its eligible entry of minimum age; equal ages resolved to lowest index.
REQ-023 alu_grant_valid = any ALU-eligible & ~flush; ALU is fully pipelined, one grant possible every cycle.
REQ-024 mdu_grant_valid = any MDU-eligible & state==IDLE & ~flush.
REQ-025 When a grant valid is 0 its idx output SHALL be 0.
REQ-026 ALU and MDU grants SHALL be independent; both may assert in the same cycle (never to the same entry, by REQ-021).
REQ-027 MDU FSM states IDLE, BUSY; counter cnt of width clog2(MDU_LAT)+1.
REQ-028 IDLE -> BUSY on mdu_grant_valid: cnt <= MDU_LAT-1, mdu_done_tag <= tag of granted entry.
REQ-029 In BUSY with cnt!=0: cnt <= cnt-1; with cnt==0: mdu_done=1 this cycle, next state IDLE.
REQ-030 Timing: grant at cycle t -> mdu_busy high t+1..t+MDU_LAT, mdu_done at t+MDU_LAT, next MDU grant earliest t+MDU_LAT+1.
REQ-031 mdu_busy = (state==BUSY); mdu_done is combinational from state/cnt and SHALL be gated by ~flush.
REQ-032 flush in any cycle: no grants, no mdu_done that cycle; next state IDLE, cnt <= 0; mdu_done_tag retained.
REQ-033 mdu_stall = any MDU-eligible & state==BUSY & ~flush.
REQ-034 RS entry deallocation on grant is the RS's duty at the same edge; arbiter holds no per-entry state.

Reset
REQ-035 reset SHALL force state IDLE, cnt 0, mdu_done_tag 0 immediately; all outputs 0 while reset is high (grants gated by reset).
REQ-036 reset asserted mid-MDU operation SHALL abandon it with no mdu_done pulse.

Verification
REQ-037 head=0, entries 2/5 ALU-eligible tags 7/3 -> alu_grant_idx=5; swap to head=6 (ages 1/13) -> alu_grant_idx=2.
REQ-038 Entries 1 and 4 both tag 9, ALU-eligible -> alu_grant_idx=1.
REQ-039 MDU_LAT=4, MDU entry tag 6 granted cycle 10 -> mdu_busy 11..14, mdu_done+tag 6 at 14, second MDU entry granted 15, mdu_stall high 11..14.
REQ-040 ALU and MDU entries both eligible in IDLE -> both grants same cycle, distinct indices.
REQ-041 flush at cycle 12 of REQ-039 run -> no grants cycle 12, mdu_busy 0 cycle 13, no mdu_done ever for tag 6.
REQ-042 reset pulse during BUSY -> outputs 0 asynchronously, IDLE after release, next MDU grant accepted first eligible cycle.
